// File: rtl/sign_mag_to_a2_pkg.sv
// Shared widths, constants and FSM state type for the sign/magnitude to two's-complement converter.
package Pkg_Global;

   localparam int DW_2  = 16;
   localparam int CNT_W = $clog2(DW_2);

   localparam logic [DW_2-1:0] ONE     = DW_2'(1);
   localparam logic [DW_2-1:0] ZERO    = '0;
   localparam logic            BIT_ONE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Parallel equivalent of the serial conversion, for use outside the datapath.
   function automatic logic [DW_2-1:0] a2_of(input logic sgn, input logic [DW_2-2:0] mag);
      logic [DW_2-1:0] ext;
      ext = {1'b0, mag};
      return sgn ? (~ext + ONE) : ext;
   endfunction

endpackage

// File: rtl/sign_mag_to_a2_if.sv
// Start/busy/done operand and result bundle between the requester and the converter.
interface sign_mag_to_a2_if;
   import Pkg_Global::*;

   logic            start;
   logic            sign;
   logic [DW_2-2:0] magnitude;
   logic            busy;
   logic            done;
   logic [DW_2-1:0] result;

   modport master (
      output start, sign, magnitude,
      input  busy, done, result
   );

   modport slave (
      input  start, sign, magnitude,
      output busy, done, result
   );

endinterface

// File: rtl/sign_mag_to_a2_serial_negate_bit.sv
// Per-bit two's-complement rule: copy bits up to and including the first one, invert after.
// Latency: combinational.
// Backpressure: none.
module serial_negate_bit (
   input  logic b_i,
   input  logic sign_i,
   input  logic seen_one_i,
   output logic out_o,
   output logic seen_one_o
);

   assign out_o      = (sign_i & seen_one_i) ? ~b_i : b_i;
   assign seen_one_o = seen_one_i | b_i;

endmodule

// File: rtl/sign_mag_to_a2.sv
// Bit-serial sign/magnitude to two's-complement converter, LSB first.
// Latency: DW_2+1 cycles from accepted start to done; one conversion per DW_2+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
module sign_mag_to_a2
   import Pkg_Global::*;
(
   input  logic            clk,
   input  logic            rst,
   sign_mag_to_a2_if.slave bus
);

   state_e           state_q, state_d;
   logic             sign_q, sign_d;
   logic [DW_2-1:0]  src_q, src_d;
   logic [DW_2-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             seen_one_q, seen_one_d;
   logic [DW_2-1:0]  result_q, result_d;
   logic             done_q, done_d;

   logic             bit_out;
   logic             seen_one_nxt;

   serial_negate_bit u_negate (
      .b_i        (src_q[0]),
      .sign_i     (sign_q),
      .seen_one_i (seen_one_q),
      .out_o      (bit_out),
      .seen_one_o (seen_one_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         sign_q     <= 1'b0;
         src_q      <= ZERO;
         acc_q      <= ZERO;
         cnt_q      <= '0;
         seen_one_q <= 1'b0;
         result_q   <= ZERO;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sign_q     <= sign_d;
         src_q      <= src_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         seen_one_q <= seen_one_d;
         result_q   <= result_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sign_d     = sign_q;
      src_d      = src_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      seen_one_d = seen_one_q;
      result_d   = result_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               sign_d     = bus.sign;
               src_d      = {1'b0, bus.magnitude};
               acc_d      = ZERO;
               cnt_d      = '0;
               seen_one_d = 1'b0;
               state_d    = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            // Result assembles MSB-in so the first processed bit lands at bit 0.
            acc_d      = {bit_out, acc_q[DW_2-1:1]};
            src_d      = {1'b0, src_q[DW_2-1:1]};
            seen_one_d = seen_one_nxt;
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DW_2 - 1)) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            result_d = acc_q;
            done_d   = BIT_ONE;
            state_d  = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.busy   = (state_q == ST_SHIFT);
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_sign_mag_to_a2.sv
// Directed and swept checks of the serial sign/magnitude to two's-complement converter.
module tb_sign_mag_to_a2;

   logic clk;
   logic rst;

   sign_mag_to_a2_if bus ();

   sign_mag_to_a2 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_prev;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Called at a negedge; start is sampled at the next posedge (E0). Returns at the
   // negedge where done is first seen (done_at = posedges after E0), or after a bound.
   task automatic run_conv(input logic s, input logic [14:0] m, input logic [15:0] prev,
                           output int busy_cnt, output int done_at,
                           output logic [15:0] res, output bit stable);
      busy_cnt = 0;
      done_at  = -1;
      stable   = 1'b1;
      bus.start     = 1'b1;
      bus.sign      = s;
      bus.magnitude = m;
      @(posedge clk);
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         bus.start     = 1'b0;
         bus.sign      = ~s;
         bus.magnitude = ~m;
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) begin
            done_at = j;
            break;
         end
         if (bus.result !== prev) stable = 1'b0;
         @(posedge clk);
      end
      res = bus.result;
   endtask

   task automatic test_reset;
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.sign      = 1'b0;
      bus.magnitude = '0;
      repeat (2) @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
      total++;
      if (bus.result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", bus.result); end
      rst      = 1'b1;
      exp_prev = 16'h0000;
   endtask

   task automatic test_positive;
      int bc, da; logic [15:0] r; bit st;
      run_conv(1'b0, 15'h1234, exp_prev, bc, da, r, st);
      total++;
      if (bc !== 16) begin bad++; $display("FAIL pos_busy_cycles got=%0d want=16", bc); end
      total++;
      if (da !== 17) begin bad++; $display("FAIL pos_done_latency got=%0d want=17", da); end
      total++;
      if (r !== 16'h1234) begin bad++; $display("FAIL pos_result got=%h want=1234", r); end
      total++;
      if (!st) begin bad++; $display("FAIL pos_result_stable got=changed want=held %h", exp_prev); end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL pos_done_width got=%b want=0", bus.done); end
      exp_prev = 16'h1234;
   endtask

   task automatic test_negative;
      logic        s_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [14:0] m_t [4] = '{15'h0001, 15'h7FFF, 15'h4000, 15'h7FFF};
      logic [15:0] e_t [4] = '{16'hFFFF, 16'h8001, 16'hC000, 16'h7FFF};
      int bc, da; logic [15:0] r; bit st;
      for (int i = 0; i < 4; i++) begin
         run_conv(s_t[i], m_t[i], exp_prev, bc, da, r, st);
         total++;
         if (r !== e_t[i]) begin
            bad++;
            $display("FAIL neg_result[%0d] s=%b m=%h got=%h want=%h", i, s_t[i], m_t[i], r, e_t[i]);
         end
         total++;
         if (!st) begin bad++; $display("FAIL neg_stable[%0d] got=changed want=held %h", i, exp_prev); end
         exp_prev = e_t[i];
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_neg_zero;
      int bc, da; logic [15:0] r; bit st;
      run_conv(1'b1, 15'h0000, exp_prev, bc, da, r, st);
      total++;
      if (r !== 16'h0000) begin bad++; $display("FAIL negzero_result got=%h want=0000", r); end
      total++;
      if (da !== 17) begin bad++; $display("FAIL negzero_done got=%0d want=17", da); end
      exp_prev = 16'h0000;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int bc, da, dones, first_done; logic [15:0] r; bit st;
      dones      = 0;
      first_done = -1;
      bus.start     = 1'b1;
      bus.sign      = 1'b0;
      bus.magnitude = 15'h1234;
      @(posedge clk);
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         // Requests while shifting (j=5) and while in DONE (j=16) must be dropped.
         bus.start     = (j == 5 || j == 16);
         bus.sign      = 1'b1;
         bus.magnitude = 15'h0005;
         if (bus.done === 1'b1) begin
            dones++;
            first_done = j;
            bus.start  = 1'b0;
            break;
         end
         @(posedge clk);
      end
      total++;
      if (first_done !== 17) begin bad++; $display("FAIL ignore_done_at got=%0d want=17", first_done); end
      total++;
      if (bus.result !== 16'h1234) begin bad++; $display("FAIL ignore_result got=%h want=1234", bus.result); end
      exp_prev = 16'h1234;
      run_conv(1'b1, 15'h0005, exp_prev, bc, da, r, st);
      total++;
      if (da !== 17) begin bad++; $display("FAIL b2b_done_at got=%0d want=17", da); end
      total++;
      if (r !== 16'hFFFB) begin bad++; $display("FAIL b2b_result got=%h want=fffb", r); end
      total++;
      if (!st) begin bad++; $display("FAIL b2b_stable got=changed want=held 1234"); end
      exp_prev = 16'hFFFB;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int dones, bc, da; logic [15:0] r; bit st;
      bus.start     = 1'b1;
      bus.sign      = 1'b0;
      bus.magnitude = 15'h0777;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", bus.busy); end
      #2 rst = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", bus.done); end
      total++;
      if (bus.result !== 16'h0000) begin bad++; $display("FAIL rstmid_result got=%h want=0000", bus.result); end
      repeat (2) @(negedge clk);
      rst   = 1'b1;
      dones = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      total++;
      if (dones !== 0) begin bad++; $display("FAIL rstmid_stray_done got=%0d want=0", dones); end
      exp_prev = 16'h0000;
      run_conv(1'b0, 15'h0ABC, exp_prev, bc, da, r, st);
      total++;
      if (r !== 16'h0ABC || da !== 17) begin
         bad++;
         $display("FAIL rstmid_after got=%h@%0d want=0abc@17", r, da);
      end
      exp_prev = 16'h0ABC;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_sweep;
      int bc, da, shown; logic [15:0] r, g; logic s; logic [14:0] m; bit st;
      shown = 0;
      for (int i = 0; i < 1000; i++) begin
         s = 1'($urandom_range(0, 1));
         m = 15'($urandom);
         g = s ? (16'h0000 - {1'b0, m}) : {1'b0, m};
         run_conv(s, m, exp_prev, bc, da, r, st);
         total++;
         if (r !== g || da !== 17 || !st) begin
            bad++;
            if (shown < 10) begin
               $display("FAIL sweep[%0d] s=%b m=%h got=%h@%0d want=%h@17", i, s, m, r, da, g);
               shown++;
            end
         end
         exp_prev = g;
      end
   endtask

   initial begin
      test_reset();
      test_positive();
      test_negative();
      test_neg_zero();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
